// File: rtl/err_metric_pkg.sv
`default_nettype none
// ============================================================================
// Module   : err_metric_pkg
// Brief    : Shared constants and FSM encoding for the error-metric accumulator
// Revision : 1.0
// ============================================================================
package err_metric_pkg;

  localparam int W_DEF     = 16;
  localparam int CNT_W_DEF = 40;
  localparam int SUM_W_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/err_dist_stage.sv
`default_nettype none
// ============================================================================
// Module   : err_dist_stage
// Brief    : Two-stage pipeline: S1 registers exact product and approximate
//            product, S2 registers their unsigned absolute difference.
// Revision : 1.0
// ============================================================================
module err_dist_stage
  import err_metric_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_x,
  input  logic [2*W-1:0]   in_prod,
  output logic             s1_valid,
  output logic             out_valid,
  output logic [2*W-1:0]   out_dist
);

  logic           s1_valid_q, s1_valid_d;
  logic [2*W-1:0] exact_q, exact_d;
  logic [2*W-1:0] approx_q, approx_d;
  logic           s2_valid_q, s2_valid_d;
  logic [2*W-1:0] dist_q, dist_d;

  // Next-state for both stages; a flush kills valid bits so nothing in flight survives
  always_comb begin
    s1_valid_d = in_valid & ~flush;
    exact_d    = (2*W)'(in_a) * (2*W)'(in_x);
    approx_d   = in_prod;
    s2_valid_d = s1_valid_q & ~flush;
    // Compare first so the subtraction never wraps
    dist_d     = (exact_q >= approx_q) ? (exact_q - approx_q) : (approx_q - exact_q);
  end

  // Pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      exact_q    <= '0;
      approx_q   <= '0;
      s2_valid_q <= 1'b0;
      dist_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      exact_q    <= exact_d;
      approx_q   <= approx_d;
      s2_valid_q <= s2_valid_d;
      dist_q     <= dist_d;
    end
  end

  assign s1_valid  = s1_valid_q;
  assign out_valid = s2_valid_q;
  assign out_dist  = dist_q;

endmodule
`default_nettype wire

// File: rtl/err_metric_accum.sv
`default_nettype none
// ============================================================================
// Module   : err_metric_accum
// Brief    : Accumulates error statistics (count, error count, sum and max of
//            absolute error distance) of an approximate multiplier sweep.
// Revision : 1.0
// ============================================================================
module err_metric_accum
  import err_metric_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int SUM_W = SUM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_x,
  input  logic [2*W-1:0]   in_prod,
  input  logic             in_last,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic [SUM_W-1:0] sum_abs_err,
  output logic [2*W-1:0]   max_abs_err
);

  state_t           state_q, state_d;
  logic             ready_q, busy_q, done_q;
  logic             accept_w;
  logic             s1_valid_w;
  logic             dist_valid_w;
  logic [2*W-1:0]   dist_w;
  logic [SUM_W:0]   sum_ext_w;

  logic [CNT_W-1:0] sample_count_q, sample_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [SUM_W-1:0] sum_abs_err_q, sum_abs_err_d;
  logic [2*W-1:0]   max_abs_err_q, max_abs_err_d;

  // A sample coinciding with start is dropped: start wins
  assign accept_w = in_valid & ready_q & ~start;

  err_dist_stage #(
    .W (W)
  ) u_dist (
    .clk       (clk),
    .rst       (rst),
    .flush     (start),
    .in_valid  (accept_w),
    .in_a      (in_a),
    .in_x      (in_x),
    .in_prod   (in_prod),
    .s1_valid  (s1_valid_w),
    .out_valid (dist_valid_w),
    .out_dist  (dist_w)
  );

  // Next state; DRAIN ends on the edge where the last sample leaves S2
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:   if (accept_w && in_last) state_d = ST_DRAIN;
        ST_DRAIN: if (!s1_valid_w)         state_d = ST_DONE;
        default:  state_d = state_q;
      endcase
    end
  end

  // State register with registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == ST_RUN);
      busy_q  <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_q  <= (state_d == ST_DONE);
    end
  end

  // Statistics update from S2 output with saturating counters and sum
  always_comb begin
    sample_count_d = sample_count_q;
    err_count_d    = err_count_q;
    sum_abs_err_d  = sum_abs_err_q;
    max_abs_err_d  = max_abs_err_q;
    sum_ext_w      = {1'b0, sum_abs_err_q} + (SUM_W+1)'(dist_w);
    if (start) begin
      sample_count_d = '0;
      err_count_d    = '0;
      sum_abs_err_d  = '0;
      max_abs_err_d  = '0;
    end else if (dist_valid_w) begin
      if (!(&sample_count_q)) sample_count_d = sample_count_q + CNT_W'(1);
      if ((dist_w != '0) && !(&err_count_q)) err_count_d = err_count_q + CNT_W'(1);
      sum_abs_err_d = sum_ext_w[SUM_W] ? {SUM_W{1'b1}} : sum_ext_w[SUM_W-1:0];
      if (dist_w > max_abs_err_q) max_abs_err_d = dist_w;
    end
  end

  // Statistics registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_count_q <= '0;
      err_count_q    <= '0;
      sum_abs_err_q  <= '0;
      max_abs_err_q  <= '0;
    end else begin
      sample_count_q <= sample_count_d;
      err_count_q    <= err_count_d;
      sum_abs_err_q  <= sum_abs_err_d;
      max_abs_err_q  <= max_abs_err_d;
    end
  end

  assign in_ready     = ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign sample_count = sample_count_q;
  assign err_count    = err_count_q;
  assign sum_abs_err  = sum_abs_err_q;
  assign max_abs_err  = max_abs_err_q;

endmodule
`default_nettype wire

// File: tb/tb_err_metric_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_err_metric_accum
// Brief    : Self-checking bench for err_metric_accum with a statistics
//            scoreboard checked on the cycle each sample should land.
// Revision : 1.0
// ============================================================================
module tb_err_metric_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_x = '0;
  logic [31:0] in_prod = '0;
  logic        in_last = 1'b0;
  logic        busy, done;
  logic [39:0] sample_count, err_count;
  logic [63:0] sum_abs_err;
  logic [31:0] max_abs_err;

  typedef struct {
    longint unsigned due;
    logic [39:0]     sc;
    logic [39:0]     ec;
    logic [63:0]     sum;
    logic [31:0]     mx;
  } exp_t;

  exp_t            q[$];
  exp_t            e_mon;
  longint unsigned cyc = 0;
  int              errors = 0;
  int              checks = 0;

  logic [39:0] m_sc, m_ec;
  logic [63:0] m_sum;
  logic [31:0] m_max;

  err_metric_accum dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_x         (in_x),
    .in_prod      (in_prod),
    .in_last      (in_last),
    .busy         (busy),
    .done         (done),
    .sample_count (sample_count),
    .err_count    (err_count),
    .sum_abs_err  (sum_abs_err),
    .max_abs_err  (max_abs_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: statistics must match the model on the exact cycle a sample lands
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due < cyc) begin
      e_mon = q.pop_front();
      checks++; errors++;
      $display("FAIL sb_missed due=%0d now=%0d", e_mon.due, cyc);
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      e_mon = q.pop_front();
      checks++;
      if ({sample_count, err_count, sum_abs_err, max_abs_err} !== {e_mon.sc, e_mon.ec, e_mon.sum, e_mon.mx}) begin
        errors++;
        $display("FAIL sb_stats cyc=%0d got sc=%0d ec=%0d sum=%0d max=%0d required sc=%0d ec=%0d sum=%0d max=%0d",
                 cyc, sample_count, err_count, sum_abs_err, max_abs_err, e_mon.sc, e_mon.ec, e_mon.sum, e_mon.mx);
      end
    end
  end

  task automatic model_clear();
    m_sc = '0; m_ec = '0; m_sum = '0; m_max = '0;
    q.delete();
  endtask

  // Offer one sample; if the DUT is ready it is accepted on the next edge
  task automatic send(input logic [15:0] a, input logic [15:0] x, input logic [31:0] p, input logic last);
    logic [31:0] ex, d;
    exp_t        e;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_x = x; in_prod = p; in_last = last;
    if (in_ready === 1'b1 && start == 1'b0) begin
      ex = {16'd0, a};
      ex = ex * {16'd0, x};
      d  = (ex >= p) ? ex - p : p - ex;
      m_sc  = m_sc + 1;
      if (d != 0) m_ec = m_ec + 1;
      m_sum = m_sum + {32'd0, d};
      if (d > m_max) m_max = d;
      e.due = cyc + 3; e.sc = m_sc; e.ec = m_ec; e.sum = m_sum; e.mx = m_max;
      q.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    model_clear();
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for done, then confirm every scoreboard entry was consumed
  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout got done=%b required 1", name, done);
    end
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_sb_pending got %0d entries required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({busy, done, in_ready} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got busy=%b done=%b ready=%b required 000", busy, done, in_ready);
    end
    checks++;
    if ({sample_count, err_count, sum_abs_err, max_abs_err} !== '0) begin
      errors++;
      $display("FAIL reset_stats got sc=%0d ec=%0d sum=%0d max=%0d required 0", sample_count, err_count, sum_abs_err, max_abs_err);
    end
    rst = 1'b0;
    // Samples offered in IDLE are ignored
    @(negedge clk);
    in_valid = 1'b1; in_a = 16'd2; in_x = 16'd2; in_prod = 32'd1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || sample_count !== 40'd0) begin
      errors++;
      $display("FAIL idle_ignore got ready=%b sc=%0d required ready=0 sc=0", in_ready, sample_count);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_single();
    pulse_start();
    checks++;
    if ({busy, done, in_ready} !== 3'b101) begin
      errors++;
      $display("FAIL single_run_flags got busy=%b done=%b ready=%b required 101", busy, done, in_ready);
    end
    send(16'd3, 16'd5, 32'd15, 1'b1);
    idle();
    wait_done("single");
    checks++;
    if ({sample_count, err_count, sum_abs_err, max_abs_err} !== {40'd1, 40'd0, 64'd0, 32'd0}) begin
      errors++;
      $display("FAIL single_final got sc=%0d ec=%0d sum=%0d max=%0d required 1 0 0 0", sample_count, err_count, sum_abs_err, max_abs_err);
    end
  endtask

  task automatic test_back_to_back();
    pulse_start();
    send(16'd100, 16'd200, 32'd19990, 1'b0);
    send(16'd7,   16'd9,   32'd64,    1'b0);
    send(16'd0,   16'd0,   32'd0,     1'b1);
    idle();
    wait_done("b2b");
    checks++;
    if ({sample_count, err_count, sum_abs_err, max_abs_err} !== {40'd3, 40'd2, 64'd11, 32'd10}) begin
      errors++;
      $display("FAIL b2b_final got sc=%0d ec=%0d sum=%0d max=%0d required 3 2 11 10", sample_count, err_count, sum_abs_err, max_abs_err);
    end
  endtask

  task automatic test_wide();
    pulse_start();
    send(16'hFFFF, 16'hFFFF, 32'd0, 1'b1);
    idle();
    wait_done("wide");
    checks++;
    if (max_abs_err !== 32'd4294836225 || sum_abs_err !== 64'd4294836225) begin
      errors++;
      $display("FAIL wide_final got max=%0d sum=%0d required 4294836225 4294836225", max_abs_err, sum_abs_err);
    end
  endtask

  // in_valid stays high through DRAIN and DONE; nothing more may be taken
  task automatic test_drain_hold();
    pulse_start();
    send(16'd2, 16'd3, 32'd9,  1'b0);
    send(16'd6, 16'd6, 32'd36, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = 16'd1; in_x = 16'd1; in_prod = 32'd5; in_last = 1'b0;
      checks++;
      if (in_ready !== 1'b0 || done !== (i >= 2)) begin
        errors++;
        $display("FAIL drain_hold_%0d got ready=%b done=%b required ready=0 done=%b", i, in_ready, done, (i >= 2));
      end
    end
    checks++;
    if ({sample_count, err_count, sum_abs_err, max_abs_err} !== {40'd2, 40'd1, 64'd3, 32'd3}) begin
      errors++;
      $display("FAIL drain_final got sc=%0d ec=%0d sum=%0d max=%0d required 2 1 3 3", sample_count, err_count, sum_abs_err, max_abs_err);
    end
    idle();
  endtask

  // DONE -> start clears statistics on the next edge
  task automatic test_restart();
    checks++;
    if (done !== 1'b1 || sample_count !== 40'd2) begin
      errors++;
      $display("FAIL restart_pre got done=%b sc=%0d required done=1 sc=2", done, sample_count);
    end
    pulse_start();
    checks++;
    if ({busy, done} !== 2'b10 || {sample_count, err_count, sum_abs_err, max_abs_err} !== '0) begin
      errors++;
      $display("FAIL restart_clear got busy=%b done=%b sc=%0d sum=%0d required busy=1 done=0 stats 0", busy, done, sample_count, sum_abs_err);
    end
  endtask

  task automatic test_rst_mid_run();
    pulse_start();
    send(16'd10, 16'd10, 32'd99, 1'b0);
    send(16'd10, 16'd10, 32'd98, 1'b0);
    send(16'd10, 16'd10, 32'd97, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, in_ready} !== 3'b000 || {sample_count, err_count, sum_abs_err, max_abs_err} !== '0) begin
      errors++;
      $display("FAIL rst_mid_immediate got busy=%b done=%b ready=%b sc=%0d sum=%0d required all 0", busy, done, in_ready, sample_count, sum_abs_err);
    end
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({busy, in_ready} !== 2'b00 || {sample_count, err_count, sum_abs_err} !== '0) begin
      errors++;
      $display("FAIL rst_mid_after got busy=%b ready=%b sc=%0d sum=%0d required 0", busy, in_ready, sample_count, sum_abs_err);
    end
    pulse_start();
    for (int i = 1; i <= 4; i++) send(16'(i), 16'(i + 3), 32'(i * (i + 3)), i == 4);
    idle();
    wait_done("rst_sweep");
    checks++;
    if (sample_count !== 40'd4 || err_count !== 40'd0) begin
      errors++;
      $display("FAIL rst_sweep_final got sc=%0d ec=%0d required 4 0", sample_count, err_count);
    end
  endtask

  // start together with an offered sample: sample dropped and pipeline flushed
  task automatic test_start_collide();
    pulse_start();
    send(16'd10, 16'd10, 32'd90, 1'b0);
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; in_a = 16'd5; in_x = 16'd5; in_prod = 32'd20; in_last = 1'b0;
    model_clear();
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({sample_count, err_count, sum_abs_err, max_abs_err} !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL collide_flush got sc=%0d ec=%0d sum=%0d busy=%b required 0 0 0 busy=1", sample_count, err_count, sum_abs_err, busy);
    end
    send(16'd4, 16'd4, 32'd16, 1'b1);
    idle();
    wait_done("collide");
    checks++;
    if ({sample_count, err_count, sum_abs_err} !== {40'd1, 40'd0, 64'd0}) begin
      errors++;
      $display("FAIL collide_final got sc=%0d ec=%0d sum=%0d required 1 0 0", sample_count, err_count, sum_abs_err);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single();
    test_back_to_back();
    test_wide();
    test_drain_hold();
    test_restart();
    test_rst_mid_run();
    test_start_collide();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/err_metric_accum.md
ERR_METRIC_ACCUM -- requirements
Module: err_metric_accum

Interface
REQ-001 SHALL have parameter W, default 16, operand width of the multiplier under evaluation.
REQ-002 SHALL have parameter CNT_W, default 40, width of sample and error counters.
REQ-003 SHALL have parameter SUM_W, default 64, width of the absolute-error-distance accumulator.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  pulse; clears statistics, enters RUN.
REQ-007 SHALL have port in_valid  input  1  sample present.
REQ-008 SHALL have port in_ready  output  1  sample accepted when in_valid and in_ready.
REQ-009 SHALL have port in_a  input  W  multiplicand fed to the multiplier.
REQ-010 SHALL have port in_x  input  W  multiplier operand.
REQ-011 SHALL have port in_prod  input  2W  approximate product from the multiplier.
REQ-012 SHALL have port in_last  input  1  marks final sample of a sweep.
REQ-013 SHALL have port busy  output  1  high in RUN or DRAIN.
REQ-014 SHALL have port done  output  1  high in DONE; statistics final.
REQ-015 SHALL have port sample_count  output  CNT_W  samples accepted.
REQ-016 SHALL have port err_count  output  CNT_W  samples with in_prod != in_a*in_x.
REQ-017 SHALL have port sum_abs_err  output  SUM_W  sum of |in_a*in_x - in_prod|.
REQ-018 SHALL have port max_abs_err  output  2W  largest |in_a*in_x - in_prod| seen.

Function
REQ-019 SHALL implement FSM IDLE, RUN, DRAIN, DONE; start from any state -> RUN with all statistics cleared and pipeline flushed.
REQ-020 SHALL drive in_ready = 1 only in RUN; samples offered in other states are ignored.
REQ-021 SHALL process samples in a 2-stage pipeline: S1 registers exact product in_a*in_x (unsigned, 2W bits) and in_prod; S2 computes error distance and updates statistics.
REQ-022 SHALL make statistics reflect an accepted sample exactly 2 cycles after the acceptance edge; one sample per cycle sustained.
REQ-023 SHALL compute error distance as unsigned |exact - approx| in 2W bits without wrap.
REQ-024 SHALL increment err_count only when error distance is non-zero; sample_count increments for every accepted sample.
REQ-025 SHALL update max_abs_err when new distance is strictly greater than stored value.
REQ-026 SHALL saturate sample_count, err_count, sum_abs_err at all-ones rather than wrap.
REQ-027 SHALL go RUN -> DRAIN on acceptance of a sample with in_last = 1; DRAIN -> DONE once both pipeline stages are empty (2 cycles).
REQ-028 SHALL hold done = 1 and statistics stable in DONE until start or rst.
REQ-029 SHALL, when start and an accepted sample coincide, discard the sample and clear statistics.

Reset
REQ-030 SHALL, on rst assertion, immediately force IDLE, in_ready = 0, busy = 0, done = 0, all statistics and pipeline valid bits to 0.
REQ-031 SHALL discard in-flight pipeline samples on rst mid-RUN; no partial update survives.

Structure
REQ-032 SHALL place FSM state enum and default W/CNT_W/SUM_W constants in shared package err_metric_pkg.
REQ-033 SHALL instantiate one sub-module err_dist_stage containing the S1/S2 exact-product and absolute-difference pipeline with valid propagation.

Verification
REQ-034 SHALL verify: start, one sample a=3,x=5,prod=15,last=1 -> after DONE sample_count=1, err_count=0, sum_abs_err=0, max_abs_err=0.
REQ-035 SHALL verify: samples (100,200,19990),(7,9,64),(0,0,0) last on third -> sample_count=3, err_count=2, sum_abs_err=11, max_abs_err=10.
REQ-036 SHALL verify: a=65535,x=65535,prod=0 -> max_abs_err=4294836225, sum_abs_err=4294836225.
REQ-037 SHALL verify: in_valid held during DRAIN and DONE -> in_ready=0, sample_count unchanged, done asserted 2 cycles after last acceptance.
REQ-038 SHALL verify: rst asserted mid-RUN with 2 samples in flight -> outputs zero same cycle, state IDLE; subsequent start sweep of 4 exact samples gives sample_count=4, err_count=0.
REQ-039 SHALL verify: start asserted in DONE -> statistics cleared next cycle, busy=1, done=0.
